// File: rtl/perf_monitor.sv
// Performance counter bank: generic pipeline events, dcache hit/miss/write-back classification, cycle counter with optional freeze.
// Latency: count visible 1 edge after the event, rd_data_o 1 edge after rd_sel_i; no backpressure, a select is accepted every cycle.
module perf_monitor #(
   parameter int unsigned     NUM_CH  = 2,
   parameter int unsigned     CNT_W   = 32,
   parameter longint unsigned LIMIT   = 0,
   localparam int unsigned    NUM_CTR = NUM_CH + 6,
   localparam int unsigned    SEL_W   = $clog2(NUM_CTR)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              clr_i,
   input  logic [NUM_CH-1:0] event_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              cache_stall_i,
   input  logic              cache_dirty_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              done_o,
   output logic              ovf_o
);

   localparam int unsigned IDX_RD_HIT  = NUM_CH;
   localparam int unsigned IDX_RD_MISS = NUM_CH + 1;
   localparam int unsigned IDX_WR_HIT  = NUM_CH + 2;
   localparam int unsigned IDX_WR_MISS = NUM_CH + 3;
   localparam int unsigned IDX_WB      = NUM_CH + 4;
   localparam int unsigned IDX_CYC     = NUM_CH + 5;

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 64'd1);

   typedef enum logic {
      EP_IDLE = 1'b0,
      EP_MISS = 1'b1
   } ep_state_e;

   ep_state_e          ep_q, ep_d;
   logic [CNT_W-1:0]   cnt_q [NUM_CTR];
   logic [CNT_W-1:0]   cnt_d [NUM_CTR];
   logic [CNT_W-1:0]   rd_q, rd_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               active;
   logic               access;
   logic [NUM_CTR-1:0] inc;

   assign active = start_i & ~done_q;
   assign access = mem_read_i | mem_write_i;

   // Miss-episode tracker: only the first stall cycle of a miss is classified,
   // and the access that completes the miss is not counted again as a hit.
   always_comb begin
      ep_d = ep_q;
      inc  = '0;
      inc[NUM_CH-1:0] = event_i;
      inc[IDX_CYC]    = 1'b1;
      case (ep_q)
         EP_IDLE: begin
            if (cache_stall_i) begin
               if (access) begin
                  if (mem_write_i) begin
                     inc[IDX_WR_MISS] = 1'b1;
                  end else begin
                     inc[IDX_RD_MISS] = 1'b1;
                  end
                  inc[IDX_WB] = cache_dirty_i;
                  ep_d        = EP_MISS;
               end
            end else begin
               inc[IDX_WR_HIT] = mem_write_i;
               inc[IDX_RD_HIT] = mem_read_i & ~mem_write_i;
            end
         end
         EP_MISS: begin
            if (!cache_stall_i) begin
               ep_d = EP_IDLE;
            end
         end
      endcase
      if (clr_i) begin
         ep_d = EP_IDLE;
      end else if (!active) begin
         ep_d = ep_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ep_q <= EP_IDLE;
      end else begin
         ep_q <= ep_d;
      end
   end

   // Saturating counters; clear wins over any increment in the same cycle.
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      done_d = done_q;
      if (clr_i) begin
         for (int i = 0; i < NUM_CTR; i++) begin
            cnt_d[i] = '0;
         end
         ovf_d  = 1'b0;
         done_d = 1'b0;
      end else if (active) begin
         for (int i = 0; i < NUM_CTR; i++) begin
            if (inc[i]) begin
               if (&cnt_q[i]) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end
         if ((LIMIT != 64'd0) && (cnt_q[IDX_CYC] == LIMIT_M1) && !(&cnt_q[IDX_CYC])) begin
            done_d = 1'b1;
         end
      end
   end

   // Readout samples the pre-update counter value; out-of-range selects give 0.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CTR; i++) begin
         if (rd_sel_i == SEL_W'(i)) begin
            rd_d = cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_CTR; i++) begin
            cnt_q[i] <= '0;
         end
         rd_q   <= '0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
         done_q <= done_d;
         ovf_q  <= ovf_d;
      end
   end

   assign rd_data_o = rd_q;
   assign done_o    = done_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Two perf_monitor instances (8-bit free-running, 16-bit with LIMIT=20) share stimulus;
// a queue of expected readouts is filled by the driver and drained by a monitor.
module tb_perf_monitor;

   localparam int NCTR = 9;
   localparam int RH   = 3;
   localparam int RM   = 4;
   localparam int WH   = 5;
   localparam int WM   = 6;
   localparam int WB   = 7;
   localparam int CYC  = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, clr;
   logic [2:0]  ev;
   logic        mrd, mwr, stall, dirty;
   logic [3:0]  sel;
   logic [7:0]  rd_a;
   logic [15:0] rd_b;
   logic        done_a, ovf_a, done_b, ovf_b;

   typedef struct packed {
      logic [7:0]  rd_a;
      logic        done_a;
      logic        ovf_a;
      logic [15:0] rd_b;
      logic        done_b;
      logic        ovf_b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   longint unsigned m_cnt [2][NCTR];
   bit              m_miss[2];
   bit              m_done[2];
   bit              m_ovf [2];
   longint unsigned m_max [2];
   longint unsigned m_lim [2];

   perf_monitor #(.NUM_CH(3), .CNT_W(8), .LIMIT(0)) u_a (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr), .event_i(ev),
      .mem_read_i(mrd), .mem_write_i(mwr), .cache_stall_i(stall), .cache_dirty_i(dirty),
      .rd_sel_i(sel), .rd_data_o(rd_a), .done_o(done_a), .ovf_o(ovf_a)
   );

   perf_monitor #(.NUM_CH(3), .CNT_W(16), .LIMIT(20)) u_b (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr), .event_i(ev),
      .mem_read_i(mrd), .mem_write_i(mwr), .cache_stall_i(stall), .cache_dirty_i(dirty),
      .rd_sel_i(sel), .rd_data_o(rd_b), .done_o(done_b), .ovf_o(ovf_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NCTR; i++) m_cnt[d][i] = 0;
         m_miss[d] = 0;
         m_done[d] = 0;
         m_ovf[d]  = 0;
      end
   endtask

   // One clock edge of the counter unit, written as a list of counters to bump.
   task automatic model_edge(input int d);
      int bumps[$];
      if (clr) begin
         for (int i = 0; i < NCTR; i++) m_cnt[d][i] = 0;
         m_miss[d] = 0;
         m_done[d] = 0;
         m_ovf[d]  = 0;
         return;
      end
      if (!start || m_done[d]) return;
      bumps.push_back(CYC);
      for (int k = 0; k < 3; k++) if (ev[k]) bumps.push_back(k);
      if (stall) begin
         if (!m_miss[d] && (mrd || mwr)) begin
            bumps.push_back(mwr ? WM : RM);
            if (dirty) bumps.push_back(WB);
            m_miss[d] = 1;
         end
      end else if (m_miss[d]) begin
         m_miss[d] = 0;
      end else if (mwr) begin
         bumps.push_back(WH);
      end else if (mrd) begin
         bumps.push_back(RH);
      end
      foreach (bumps[j]) begin
         if (m_cnt[d][bumps[j]] == m_max[d]) m_ovf[d] = 1;
         else m_cnt[d][bumps[j]]++;
      end
      if (m_lim[d] != 0 && m_cnt[d][CYC] == m_lim[d]) m_done[d] = 1;
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      exp_t e;
      int   s;
      s = int'(sel);
      e = '0;
      if (s < NCTR) begin
         e.rd_a = 8'(m_cnt[0][s]);
         e.rd_b = 16'(m_cnt[1][s]);
      end
      model_edge(0);
      model_edge(1);
      e.done_a = m_done[0];
      e.ovf_a  = m_ovf[0];
      e.done_b = m_done[1];
      e.ovf_b  = m_ovf[1];
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic set_in(input bit st, input bit cl, input logic [2:0] e, input bit r,
                         input bit w, input bit sl, input bit dy, input logic [3:0] s);
      start = st; clr = cl; ev = e; mrd = r; mwr = w; stall = sl; dirty = dy; sel = s;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rd_a", rd_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_ovf_a", ovf_a, 0);
      check("rst_rd_b", rd_b, 0);
      check("rst_done_b", done_b, 0);
      check("rst_ovf_b", ovf_b, 0);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic readback();
      for (int s = 0; s < 16; s++) begin
         set_in(0, 0, 3'b000, 0, 0, 0, 0, 4'(s));
         tick();
      end
   endtask

   task automatic do_clr();
      set_in(0, 1, 3'b000, 0, 0, 0, 0, 4'd0);
      tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_a", rd_a, e.rd_a);
            check("done_a", done_a, e.done_a);
            check("ovf_a", ovf_a, e.ovf_a);
            check("rd_b", rd_b, e.rd_b);
            check("done_b", done_b, e.done_b);
            check("ovf_b", ovf_b, e.ovf_b);
         end
      end
   end

   initial begin : driver
      m_max[0] = 255;
      m_max[1] = 65535;
      m_lim[0] = 0;
      m_lim[1] = 20;
      rst_n = 1'b1;
      set_in(0, 0, 3'b000, 0, 0, 0, 0, 4'd0);
      @(negedge clk);
      do_reset();

      // Single event channel for ten cycles, then a few idle active cycles.
      for (int i = 0; i < 10; i++) begin set_in(1, 0, 3'b001, 0, 0, 0, 0, 4'd0); tick(); end
      for (int i = 0; i < 3; i++)  begin set_in(1, 0, 3'b000, 0, 0, 0, 0, 4'd8); tick(); end
      readback();

      // Dirty read miss over four stall cycles, completing access, then a clean hit.
      do_clr();
      set_in(1, 0, 3'b000, 1, 0, 1, 1, 4'd4); tick();
      for (int i = 0; i < 3; i++) begin set_in(1, 0, 3'b000, 1, 0, 1, 0, 4'd4); tick(); end
      set_in(1, 0, 3'b000, 1, 0, 0, 0, 4'd3); tick();
      set_in(1, 0, 3'b000, 1, 0, 0, 0, 4'd3); tick();
      readback();

      // Read and write both asserted during a miss: classified as a write.
      do_clr();
      for (int i = 0; i < 2; i++) begin set_in(1, 0, 3'b000, 1, 1, 1, 0, 4'd6); tick(); end
      set_in(1, 0, 3'b000, 1, 1, 0, 0, 4'd6); tick();
      set_in(1, 0, 3'b000, 0, 1, 0, 0, 4'd5); tick();
      readback();

      // Saturation of the 8-bit instance; the 16-bit instance freezes at its limit.
      do_clr();
      for (int i = 0; i < 300; i++) begin set_in(1, 0, 3'b111, 0, 0, 0, 0, 4'd0); tick(); end
      readback();
      do_clr();
      readback();

      // Cycle limit, then clear.
      for (int i = 0; i < 25; i++) begin set_in(1, 0, 3'b010, 0, 0, 0, 0, 4'd8); tick(); end
      readback();
      do_clr();
      readback();

      // Clear and event in the same cycle; out-of-range select.
      set_in(1, 0, 3'b001, 0, 0, 0, 0, 4'd0); tick();
      set_in(1, 1, 3'b001, 0, 0, 0, 0, 4'd10); tick();
      set_in(0, 0, 3'b000, 0, 0, 0, 0, 4'd10); tick();
      readback();

      // Reset in the middle of a miss, stall continuing afterwards.
      do_clr();
      for (int i = 0; i < 2; i++) begin set_in(1, 0, 3'b001, 1, 0, 1, 0, 4'd4); tick(); end
      do_reset();
      for (int i = 0; i < 2; i++) begin set_in(1, 0, 3'b000, 1, 0, 1, 1, 4'd4); tick(); end
      set_in(1, 0, 3'b000, 1, 0, 0, 0, 4'd3); tick();
      readback();

      // Start dropped mid-miss: the episode must survive the pause.
      do_clr();
      set_in(1, 0, 3'b000, 0, 1, 1, 0, 4'd6); tick();
      for (int i = 0; i < 3; i++) begin set_in(0, 0, 3'b000, 1, 0, 0, 0, 4'd6); tick(); end
      set_in(1, 0, 3'b000, 0, 1, 0, 0, 4'd5); tick();
      set_in(1, 0, 3'b000, 0, 1, 0, 0, 4'd5); tick();
      readback();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         if ($urandom_range(0, 3) == 0) stall = ~stall;
         start = ($urandom_range(0, 7) != 0);
         clr   = ($urandom_range(0, 39) == 0);
         ev    = 3'($urandom);
         mrd   = 1'($urandom);
         mwr   = ($urandom_range(0, 2) == 0);
         dirty = 1'($urandom);
         sel   = 4'($urandom);
         tick();
      end
      readback();

      check("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
